// File: rtl/injector_seq_ctrl_if.sv
// Wishbone slave bus bundle for the injector sequencer.
interface injector_seq_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/injector_seq_ctrl.sv
// Wishbone-programmable SETTLE -> LATCH -> RUN sequencer driving the
// differential charge-injector macro, with looping, abort and completion IRQ.
module injector_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned SETTLE_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  injector_seq_ctrl_if.slave   wb,
  output logic                 inj_enable,
  output logic [3:0]           inj_trim_p,
  output logic [3:0]           inj_trim_n,
  output logic                 inj_latch,
  output logic [31:0]          inj_signal,
  output logic                 irq
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned OFF_W = 3;

  localparam logic [OFF_W-1:0] OFF_CTRL    = 3'd0;
  localparam logic [OFF_W-1:0] OFF_TRIM    = 3'd1;
  localparam logic [OFF_W-1:0] OFF_PATTERN = 3'd2;
  localparam logic [OFF_W-1:0] OFF_TIMING  = 3'd3;
  localparam logic [OFF_W-1:0] OFF_STATUS  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LATCH  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;

  // programmer-visible registers
  logic               ctrl_loop, ctrl_irq_en;
  logic [3:0]         trim_p_r, trim_n_r;
  logic [31:0]        pattern_r;
  logic [SETTLE_W-1:0] settle_r;
  logic [7:0]         latch_w_r;
  logic [15:0]        burst_r;
  logic               done_r;

  // copies frozen at START so the running sequence ignores later writes
  logic [3:0]         sh_trim_p, sh_trim_n;
  logic [31:0]        sh_pattern;
  logic [7:0]         sh_latch_w;
  logic [15:0]        sh_burst;

  logic               req_c, wr_c, ctrl_wr_c, start_c, abort_c, done_clr_c;
  logic               load_shadow_c, done_set_c, done_d, irq_en_d;
  logic [OFF_W-1:0]   off_c;
  logic [31:0]        rd_data_c;
  logic               unused_adr;

  logic               en_d, latch_d, irq_d;
  logic [3:0]         tp_d, tn_d, sh_tp_n, sh_tn_n;
  logic [31:0]        sig_d, sh_pat_n;

  assign req_c      = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o &
                      (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign wr_c       = req_c & wb.wbs_we_i;
  assign off_c      = wb.wbs_adr_i[4:2];
  assign unused_adr = ^wb.wbs_adr_i[1:0];
  assign ctrl_wr_c  = wr_c & (off_c == OFF_CTRL) & wb.wbs_sel_i[0];
  assign start_c    = ctrl_wr_c & wb.wbs_dat_i[0] & ~wb.wbs_dat_i[1];
  assign abort_c    = ctrl_wr_c & wb.wbs_dat_i[1];
  assign done_clr_c = wr_c & (off_c == OFF_STATUS) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];

  // a completion on the same edge as a W1C keeps DONE set
  assign done_d   = done_set_c | (done_r & ~done_clr_c);
  assign irq_en_d = ctrl_wr_c ? wb.wbs_dat_i[3] : ctrl_irq_en;
  assign irq_d    = done_d & irq_en_d;

  function automatic logic [CNT_W-1:0] latch_load(input logic [7:0] w);
    return (w == 8'd0) ? '0 : CNT_W'(w - 8'd1);
  endfunction

  function automatic logic [CNT_W-1:0] run_load(input logic [15:0] b);
    return (b == 16'd0) ? '0 : CNT_W'(b - 16'd1);
  endfunction

  // register read mux
  always_comb begin
    rd_data_c = '0;
    case (off_c)
      OFF_CTRL:    rd_data_c = {28'd0, ctrl_irq_en, ctrl_loop, 2'b00};
      OFF_TRIM:    rd_data_c = {24'd0, trim_n_r, trim_p_r};
      OFF_PATTERN: rd_data_c = pattern_r;
      OFF_TIMING:  rd_data_c = {burst_r, latch_w_r, 8'(settle_r)};
      OFF_STATUS:  rd_data_c = {28'd0, state, done_r, (state != ST_IDLE)};
      default:     rd_data_c = '0;
    endcase
  end

  // next state, counter and next registered outputs
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    load_shadow_c = 1'b0;
    done_set_c    = 1'b0;
    en_d          = 1'b0;
    latch_d       = 1'b0;
    sig_d         = '0;
    tp_d          = '0;
    tn_d          = '0;

    case (state)
      ST_IDLE: begin
        if (start_c) begin
          state_d       = ST_SETTLE;
          cnt_d         = CNT_W'(settle_r);
          load_shadow_c = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_d = ST_LATCH;
          cnt_d   = latch_load(sh_latch_w);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (cnt == '0) begin
          state_d = ST_RUN;
          cnt_d   = run_load(sh_burst);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (sh_burst == 16'd0) begin
          cnt_d = '0;
        end else if (cnt == '0) begin
          if (ctrl_loop) begin
            state_d = ST_LATCH;
            cnt_d   = latch_load(sh_latch_w);
          end else begin
            state_d    = ST_IDLE;
            done_set_c = 1'b1;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_c && (state != ST_IDLE)) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      done_set_c = 1'b0;
    end

    sh_tp_n  = load_shadow_c ? trim_p_r  : sh_trim_p;
    sh_tn_n  = load_shadow_c ? trim_n_r  : sh_trim_n;
    sh_pat_n = load_shadow_c ? pattern_r : sh_pattern;

    if (state_d != ST_IDLE) begin
      en_d = 1'b1;
      tp_d = sh_tp_n;
      tn_d = sh_tn_n;
    end
    latch_d = (state_d == ST_LATCH);
    if (state_d == ST_RUN) sig_d = sh_pat_n;
  end

  // sequencer state and injector output flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      inj_enable <= 1'b0;
      inj_latch  <= 1'b0;
      inj_signal <= '0;
      inj_trim_p <= '0;
      inj_trim_n <= '0;
      irq        <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      inj_enable <= en_d;
      inj_latch  <= latch_d;
      inj_signal <= sig_d;
      inj_trim_p <= tp_d;
      inj_trim_n <= tn_d;
      irq        <= irq_d;
    end
  end

  // register file, shadows and bus response
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_loop     <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      trim_p_r      <= '0;
      trim_n_r      <= '0;
      pattern_r     <= '0;
      settle_r      <= '0;
      latch_w_r     <= '0;
      burst_r       <= '0;
      done_r        <= 1'b0;
      sh_trim_p     <= '0;
      sh_trim_n     <= '0;
      sh_pattern    <= '0;
      sh_latch_w    <= '0;
      sh_burst      <= '0;
      wb.wbs_ack_o  <= 1'b0;
      wb.wbs_dat_o  <= '0;
    end else begin
      if (ctrl_wr_c) begin
        ctrl_loop   <= wb.wbs_dat_i[2];
        ctrl_irq_en <= wb.wbs_dat_i[3];
      end
      if (wr_c && (off_c == OFF_TRIM) && wb.wbs_sel_i[0]) begin
        trim_p_r <= wb.wbs_dat_i[3:0];
        trim_n_r <= wb.wbs_dat_i[7:4];
      end
      if (wr_c && (off_c == OFF_PATTERN)) begin
        for (int b = 0; b < 4; b++) begin
          if (wb.wbs_sel_i[b]) pattern_r[8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
        end
      end
      if (wr_c && (off_c == OFF_TIMING)) begin
        if (wb.wbs_sel_i[0]) settle_r       <= wb.wbs_dat_i[SETTLE_W-1:0];
        if (wb.wbs_sel_i[1]) latch_w_r      <= wb.wbs_dat_i[15:8];
        if (wb.wbs_sel_i[2]) burst_r[7:0]   <= wb.wbs_dat_i[23:16];
        if (wb.wbs_sel_i[3]) burst_r[15:8]  <= wb.wbs_dat_i[31:24];
      end
      done_r <= done_d;
      if (load_shadow_c) begin
        sh_trim_p  <= trim_p_r;
        sh_trim_n  <= trim_n_r;
        sh_pattern <= pattern_r;
        sh_latch_w <= latch_w_r;
        sh_burst   <= burst_r;
      end
      wb.wbs_ack_o <= req_c;
      wb.wbs_dat_o <= (req_c && !wb.wbs_we_i) ? rd_data_c : '0;
    end
  end

endmodule

// File: tb/tb_injector_seq_ctrl.sv
// Self-checking bench for injector_seq_ctrl: directed scenarios plus randomized
// sequences compared against a cycle-list reference model.
module tb_injector_seq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [4:0]  R_CTRL = 5'h00, R_TRIM = 5'h04, R_PAT = 5'h08,
                          R_TIM = 5'h0C, R_STAT = 5'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        inj_enable, inj_latch, irq;
  logic [3:0]  inj_trim_p, inj_trim_n;
  logic [31:0] inj_signal;

  always #5 clk = ~clk;

  injector_seq_ctrl_if bus();

  injector_seq_ctrl #(.BASE_ADDR(BASE), .SETTLE_W(8)) dut (
    .clk(clk), .reset(reset), .wb(bus),
    .inj_enable(inj_enable), .inj_trim_p(inj_trim_p), .inj_trim_n(inj_trim_n),
    .inj_latch(inj_latch), .inj_signal(inj_signal), .irq(irq)
  );

  typedef struct packed {
    logic        en;
    logic        lat;
    logic [31:0] sig;
    logic [3:0]  tp;
    logic [3:0]  tn;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic done_m   = 1'b0;

  function automatic obs_t observed();
    return {inj_enable, inj_latch, inj_signal, inj_trim_p, inj_trim_n};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [4:0] off, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd);
    int k;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_adr_i = BASE | 32'(off); bus.wbs_dat_i = d;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!bus.wbs_ack_o && k < 4);
    chk("ack", 64'(bus.wbs_ack_o), 64'd1);
    rd = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, off, d, 4'hF, dummy);
  endtask

  task automatic read_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    wb_access(1'b0, off, 32'd0, 4'hF, rd);
    chk(tag, 64'(rd), 64'(exp));
  endtask

  // Reference: expected per-cycle outputs from the moment START commits.
  task automatic plan(input int st, input int lw, input int bu, input logic [7:0] trim,
                      input logic [31:0] pat, input int reps);
    int nl;
    nl = (lw == 0) ? 1 : lw;
    exp_q.delete();
    for (int i = 0; i <= st; i++) exp_q.push_back({1'b1, 1'b0, 32'd0, trim[3:0], trim[7:4]});
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nl; i++) exp_q.push_back({1'b1, 1'b1, 32'd0, trim[3:0], trim[7:4]});
      for (int i = 0; i < bu; i++) exp_q.push_back({1'b1, 1'b0, pat, trim[3:0], trim[7:4]});
    end
  endtask

  task automatic run_check(input string tag, input logic irq_en_m, input logic expect_end);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      chk(tag, 64'(observed()), 64'(exp_q[i]));
      chk({tag, "_irq"}, 64'(irq), 64'(done_m & irq_en_m));
    end
    if (expect_end) begin
      @(posedge clk); #1;
      done_m = 1'b1;
      chk({tag, "_idle"}, 64'(observed()), 64'd0);
      chk({tag, "_irq_end"}, 64'(irq), 64'(irq_en_m));
    end
  endtask

  task automatic clear_done();
    wb_write(R_STAT, 32'h2);
    done_m = 1'b0;
  endtask

  initial begin
    logic [31:0] pat, rd;
    logic [7:0]  trim;
    logic        ie;
    int          st, lw, bu, k;

    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;

    // reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 64'(observed()), 64'd0);
    chk("rst_ack", 64'(bus.wbs_ack_o), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    @(negedge clk) reset = 1'b0;
    read_chk("rst_status", R_STAT, 32'h0);

    // basic sequence
    wb_write(R_TRIM, 32'h5A);
    wb_write(R_PAT, 32'hDEADBEEF);
    wb_write(R_TIM, 32'h0004_0203);
    wb_write(R_CTRL, 32'h1);
    plan(3, 2, 4, 8'h5A, 32'hDEADBEEF, 1);
    run_check("basic", 1'b0, 1'b1);
    read_chk("basic_status", R_STAT, 32'h2);

    // IRQ and W1C
    clear_done();
    chk("irq_cleared", 64'(irq), 64'd0);
    wb_write(R_CTRL, 32'h9);
    run_check("irqseq", 1'b1, 1'b1);
    wb_write(R_STAT, 32'h2);
    done_m = 1'b0;
    @(posedge clk); #1;
    chk("irq_fall", 64'(irq), 64'd0);
    read_chk("ctrl_rb", R_CTRL, 32'h8);

    // byte-select masking
    wb_access(1'b1, R_TRIM, 32'hFF, 4'h0, rd);
    read_chk("sel_none", R_TRIM, 32'h5A);
    wb_access(1'b1, R_PAT, 32'h1122_3344, 4'b0101, rd);
    read_chk("sel_pat", R_PAT, 32'hDE22_BE44);
    wb_write(R_PAT, 32'hDEADBEEF);

    // shadowing, START while busy, burst=0 then ABORT
    wb_write(R_TIM, 32'h0000_0102);
    wb_write(R_CTRL, 32'h1);
    k = 0;
    while (inj_signal !== 32'hDEADBEEF && k < 40) begin @(posedge clk); #1; k++; end
    chk("reach_run", 64'(inj_signal), 64'hDEADBEEF);
    wb_write(R_PAT, 32'h0);
    wb_write(R_TRIM, 32'h33);
    chk("shadow_sig", 64'(inj_signal), 64'hDEADBEEF);
    chk("shadow_trim", 64'({inj_trim_n, inj_trim_p}), 64'h5A);
    wb_write(R_CTRL, 32'h1);
    read_chk("busy_status", R_STAT, 32'hD);
    read_chk("pat_rb", R_PAT, 32'h0);
    read_chk("trim_rb", R_TRIM, 32'h33);
    chk("still_run", 64'(inj_enable), 64'd1);
    wb_write(R_CTRL, 32'h2);
    chk("abort_outs", 64'(observed()), 64'd0);
    read_chk("abort_status", R_STAT, 32'h0);

    // loop then abort
    pat = $urandom();
    wb_write(R_PAT, pat);
    wb_write(R_TIM, 32'h0003_0100);
    wb_write(R_CTRL, 32'h5);
    plan(0, 1, 3, 8'h33, pat, 3);
    run_check("loop", 1'b0, 1'b0);
    wb_write(R_CTRL, 32'h2);
    chk("loop_abort", 64'(observed()), 64'd0);
    read_chk("loop_status", R_STAT, 32'h0);

    // settle = 0, latch_w = 0
    wb_write(R_TIM, 32'h0002_0000);
    wb_write(R_CTRL, 32'h1);
    plan(0, 0, 2, 8'h33, pat, 1);
    run_check("zero_tim", 1'b0, 1'b1);
    read_chk("zero_status", R_STAT, 32'h2);
    clear_done();

    // ABORT and START together in IDLE
    wb_write(R_CTRL, 32'h3);
    @(posedge clk); #1;
    chk("ctrl3_en", 64'(inj_enable), 64'd0);
    read_chk("ctrl3_status", R_STAT, 32'h0);

    // randomized sequences
    for (int it = 0; it < 6; it++) begin
      st   = int'($urandom_range(0, 4));
      lw   = int'($urandom_range(0, 3));
      bu   = int'($urandom_range(1, 5));
      trim = 8'($urandom());
      pat  = $urandom();
      ie   = 1'($urandom());
      wb_write(R_TRIM, 32'(trim));
      wb_write(R_PAT, pat);
      wb_write(R_TIM, {16'(bu), 8'(lw), 8'(st)});
      wb_write(R_CTRL, {28'd0, ie, 3'b001});
      plan(st, lw, bu, trim, pat, 1);
      run_check("rand", ie, 1'b1);
      read_chk("rand_status", R_STAT, 32'h2);
      clear_done();
      chk("rand_irq_clr", 64'(irq), 64'd0);
    end

    // reset during LATCH
    wb_write(R_TIM, 32'h0002_0602);
    wb_write(R_CTRL, 32'h9);
    k = 0;
    while (inj_latch !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("reach_latch", 64'(inj_latch), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE | 32'(R_STAT);
    @(posedge clk); #1;
    chk("rst_mid_outs", 64'(observed()), 64'd0);
    chk("rst_mid_ack", 64'(bus.wbs_ack_o), 64'd0);
    chk("rst_mid_irq", 64'(irq), 64'd0);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk) reset = 1'b0;
    done_m = 1'b0;
    read_chk("rst_mid_status", R_STAT, 32'h0);
    read_chk("rst_mid_ctrl", R_CTRL, 32'h0);

    // unmapped offset
    read_chk("off14", 5'h14, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
